regfile_pipe: RTL and testbench

Parametrised register file for the NanoQuarter datapath with deferred writeback. A destination address issued in one cycle is carried through a WB_LAT-deep delay line. The matching data_in is committed WB_LAT cycles later. The block adds optional same-cycle write-to-read bypass, an optional hardwired-zero R0, and per-source busy flags so the issue stage can stall on pending writes.

---
 rtl/regfile_pipe.sv | 84 ++++++++
 tb/tb_regfile_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_pipe.sv
// Register file with deferred writeback: destination addresses ride a WB_LAT-deep
// delay line and commit data_in when they reach the last stage.
module regfile_pipe #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int WB_LAT  = 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wp,
  output logic [DATA_W-1:0] reg1data,
  output logic [DATA_W-1:0] reg2data,
  output logic              busy1,
  output logic              busy2
);

  localparam int NREGS  = 2 ** ADDR_W;
  // The committing stage drops out of the busy range when its data is forwarded.
  localparam int BUSY_N = (BYPASS != 0) ? WB_LAT - 1 : WB_LAT;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [WB_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [WB_LAT];

  logic              cmt_vld;
  logic [ADDR_W-1:0] cmt_addr;
  logic              cmt_wr;
  logic              fwd1, fwd2;
  logic              hit1, hit2;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  assign cmt_vld  = vld_q[WB_LAT-1];
  assign cmt_addr = addr_q[WB_LAT-1];
  assign cmt_wr   = cmt_vld && wp && !is_zero_reg(cmt_addr);

  assign fwd1 = (BYPASS != 0) && cmt_vld && wp && (cmt_addr == rs1);
  assign fwd2 = (BYPASS != 0) && cmt_vld && wp && (cmt_addr == rs2);

  assign reg1data = is_zero_reg(rs1) ? '0 : (fwd1 ? data_in : regs_q[rs1]);
  assign reg2data = is_zero_reg(rs2) ? '0 : (fwd2 ? data_in : regs_q[rs2]);

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int k = 0; k < WB_LAT; k++) begin
      if (k < BUSY_N && vld_q[k]) begin
        if (addr_q[k] == rs1) hit1 = 1'b1;
        if (addr_q[k] == rs2) hit2 = 1'b1;
      end
    end
  end

  assign busy1 = hit1 && !is_zero_reg(rs1);
  assign busy2 = hit2 && !is_zero_reg(rs2);

  // Stage valids and the register array are architectural state and clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      vld_q[0] <= rd_valid;
      for (int k = 1; k < WB_LAT; k++) vld_q[k] <= vld_q[k-1];
      if (cmt_wr) regs_q[cmt_addr] <= data_in;
    end
  end

  // Addresses are only meaningful alongside their valid bit.
  always_ff @(posedge clk) begin
    addr_q[0] <= rd;
    for (int k = 1; k < WB_LAT; k++) addr_q[k] <= addr_q[k-1];
  end

endmodule

// File: tb/tb_regfile_pipe.sv
// Bench for regfile_pipe: four parameter variants share one stimulus stream and are
// checked every cycle against a history-based reference model plus directed scenarios.
module tb_regfile_pipe;

  logic        clk;
  logic        rst;
  logic [2:0]  rs1, rs2, rd;
  logic        rd_valid;
  logic [15:0] data_in;
  logic        wp;

  logic [15:0] r1 [4];
  logic [15:0] r2 [4];
  logic        b1 [4];
  logic        b2 [4];

  int lat_t [4] = '{1, 3, 2, 2};
  int bp_t  [4] = '{0, 1, 0, 1};
  int zr_t  [4] = '{0, 0, 0, 1};

  regfile_pipe #(.DATA_W(16), .ADDR_W(3), .WB_LAT(1), .BYPASS(0), .ZERO_R0(0)) u_a (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .rd_valid(rd_valid),
    .data_in(data_in), .wp(wp), .reg1data(r1[0]), .reg2data(r2[0]), .busy1(b1[0]), .busy2(b2[0]));
  regfile_pipe #(.DATA_W(16), .ADDR_W(3), .WB_LAT(3), .BYPASS(1), .ZERO_R0(0)) u_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .rd_valid(rd_valid),
    .data_in(data_in), .wp(wp), .reg1data(r1[1]), .reg2data(r2[1]), .busy1(b1[1]), .busy2(b2[1]));
  regfile_pipe #(.DATA_W(16), .ADDR_W(3), .WB_LAT(2), .BYPASS(0), .ZERO_R0(0)) u_c (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .rd_valid(rd_valid),
    .data_in(data_in), .wp(wp), .reg1data(r1[2]), .reg2data(r2[2]), .busy1(b1[2]), .busy2(b2[2]));
  regfile_pipe #(.DATA_W(16), .ADDR_W(3), .WB_LAT(2), .BYPASS(1), .ZERO_R0(1)) u_d (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .rd_valid(rd_valid),
    .data_in(data_in), .wp(wp), .reg1data(r1[3]), .reg2data(r2[3]), .busy1(b1[3]), .busy2(b2[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-cycle issue history and per-variant register contents.
  int          cyc = 0;
  logic        hv [4096];
  logic [2:0]  ha [4096];
  logic [15:0] mregs [4][8];

  function automatic logic [15:0] exp_rd(input int i, input logic [2:0] rs);
    int j;
    j = cyc - lat_t[i];
    if (zr_t[i] != 0 && rs == 3'd0) return 16'h0;
    if (bp_t[i] != 0 && j >= 0 && hv[j] && ha[j] == rs && wp) return data_in;
    return mregs[i][rs];
  endfunction

  function automatic logic exp_busy(input int i, input logic [2:0] rs);
    int lo;
    lo = cyc - lat_t[i] + ((bp_t[i] != 0) ? 1 : 0);
    if (zr_t[i] != 0 && rs == 3'd0) return 1'b0;
    for (int j = lo; j < cyc; j++)
      if (j >= 0 && hv[j] && ha[j] == rs) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    int          inst;
    int          fld;
    logic [15:0] exp;
  } sb_t;
  sb_t sbq[$];

  task automatic push_model();
    sb_t e;
    for (int i = 0; i < 4; i++) begin
      e.inst = i; e.fld = 0; e.exp = exp_rd(i, rs1);              sbq.push_back(e);
      e.inst = i; e.fld = 1; e.exp = exp_rd(i, rs2);              sbq.push_back(e);
      e.inst = i; e.fld = 2; e.exp = 16'(exp_busy(i, rs1));       sbq.push_back(e);
      e.inst = i; e.fld = 3; e.exp = 16'(exp_busy(i, rs2));       sbq.push_back(e);
    end
  endtask

  function automatic logic [15:0] obs_of(input int i, input int f);
    case (f)
      0:       return r1[i];
      1:       return r2[i];
      2:       return 16'(b1[i]);
      default: return 16'(b2[i]);
    endcase
  endfunction

  function automatic string fname(input int f);
    case (f)
      0:       return "reg1data";
      1:       return "reg2data";
      2:       return "busy1";
      default: return "busy2";
    endcase
  endfunction

  always @(negedge clk) begin
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("sb_u%0d_%s_c%0d", e.inst, fname(e.fld), cyc), obs_of(e.inst, e.fld), e.exp);
    end
  end

  task automatic drive(input logic v, input logic [2:0] a, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [15:0] d, input logic w);
    rd_valid = v; rd = a; rs1 = s1; rs2 = s2; data_in = d; wp = w;
    #1;
    push_model();
  endtask

  task automatic tick();
    int j;
    for (int i = 0; i < 4; i++) begin
      j = cyc - lat_t[i];
      if (!rst && j >= 0 && hv[j] && wp && !(zr_t[i] != 0 && ha[j] == 3'd0))
        mregs[i][ha[j]] = data_in;
    end
    hv[cyc] = rst ? 1'b0 : rd_valid;
    ha[cyc] = rd;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 8; r++) mregs[i][r] = 16'h0;
    for (int j = 0; j <= cyc; j++) hv[j] = 1'b0;
    push_model();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_u%0d_r1", i), r1[i], 16'h0);
      chk($sformatf("rst_u%0d_r2", i), r2[i], 16'h0);
      chk($sformatf("rst_u%0d_b1", i), 16'(b1[i]), 16'h0);
      chk($sformatf("rst_u%0d_b2", i), 16'(b2[i]), 16'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] pa;
    for (int j = 0; j < 4096; j++) begin hv[j] = 1'b0; ha[j] = 3'd0; end
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 8; r++) mregs[i][r] = 16'h0;
    rst = 1'b1; rd_valid = 1'b0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0; data_in = 16'h0; wp = 1'b0;
    @(posedge clk); #1;
    drive(1, 3'd6, 3'd6, 3'd1, 16'h7777, 1); tick();
    drive(1, 3'd6, 3'd6, 3'd1, 16'h7777, 1); tick();
    rst = 1'b0;

    // WB_LAT=1, no bypass
    drive(1, 3'd3, 3'd3, 3'd3, 16'h0, 0); tick();
    drive(0, 3'd0, 3'd3, 3'd3, 16'hBEEF, 1);
    chk("A_c1_r1", r1[0], 16'h0); chk("A_c1_b1", 16'(b1[0]), 16'h1); tick();
    drive(0, 3'd0, 3'd3, 3'd3, 16'h0, 0);
    chk("A_c2_r1", r1[0], 16'hBEEF); chk("A_c2_b1", 16'(b1[0]), 16'h0); tick();

    // WB_LAT=3 with bypass
    drive(1, 3'd5, 3'd5, 3'd5, 16'h0, 0); tick();
    drive(0, 3'd0, 3'd5, 3'd5, 16'h0, 0); chk("B_c1_b1", 16'(b1[1]), 16'h1); tick();
    drive(0, 3'd0, 3'd5, 3'd5, 16'h0, 0); chk("B_c2_b1", 16'(b1[1]), 16'h1); tick();
    drive(0, 3'd0, 3'd5, 3'd5, 16'h1234, 1);
    chk("B_c3_r1", r1[1], 16'h1234); chk("B_c3_b1", 16'(b1[1]), 16'h0); tick();
    drive(0, 3'd0, 3'd5, 3'd5, 16'h0, 0); chk("B_c4_r1", r1[1], 16'h1234); tick();

    // Dropped write, WB_LAT=2 no bypass
    drive(1, 3'd2, 3'd2, 3'd2, 16'h0, 0); tick();
    drive(0, 3'd0, 3'd2, 3'd2, 16'h0, 0); tick();
    drive(0, 3'd0, 3'd2, 3'd2, 16'h00AA, 1); tick();
    drive(1, 3'd2, 3'd2, 3'd2, 16'h0, 0); chk("C_set_r1", r1[2], 16'h00AA); tick();
    drive(0, 3'd0, 3'd2, 3'd2, 16'h0, 0); chk("C_drop_b1_c1", 16'(b1[2]), 16'h1); tick();
    drive(0, 3'd0, 3'd2, 3'd2, 16'hFFFF, 0);
    chk("C_drop_b1_c2", 16'(b1[2]), 16'h1); chk("C_drop_r1_c2", r1[2], 16'h00AA); tick();
    drive(0, 3'd0, 3'd2, 3'd2, 16'h0, 0);
    chk("C_drop_r1_c3", r1[2], 16'h00AA); chk("C_drop_b1_c3", 16'(b1[2]), 16'h0); tick();

    // Same-address back-to-back, WB_LAT=2
    drive(1, 3'd4, 3'd4, 3'd4, 16'h0, 0); tick();
    drive(1, 3'd4, 3'd4, 3'd4, 16'h0, 0); chk("S_c1_b1", 16'(b1[2]), 16'h1); tick();
    drive(0, 3'd0, 3'd4, 3'd4, 16'h0001, 1); chk("S_c2_b1", 16'(b1[2]), 16'h1); tick();
    drive(0, 3'd0, 3'd4, 3'd4, 16'h0002, 1);
    chk("S_c3_b1", 16'(b1[2]), 16'h1); chk("S_c3_r1", r1[2], 16'h0001); tick();
    drive(0, 3'd0, 3'd4, 3'd4, 16'h0, 0);
    chk("S_c4_b1", 16'(b1[2]), 16'h0); chk("S_c4_r1", r1[2], 16'h0002); tick();

    // Hardwired R0 with bypass
    drive(1, 3'd0, 3'd0, 3'd0, 16'h0, 0); chk("Z_c0_b1", 16'(b1[3]), 16'h0); tick();
    drive(0, 3'd0, 3'd0, 3'd0, 16'h0, 0);
    chk("Z_c1_b1", 16'(b1[3]), 16'h0); chk("Z_c1_r1", r1[3], 16'h0); tick();
    drive(0, 3'd0, 3'd0, 3'd0, 16'h5555, 1);
    chk("Z_c2_b1", 16'(b1[3]), 16'h0); chk("Z_c2_r1", r1[3], 16'h0); tick();
    drive(0, 3'd0, 3'd0, 3'd0, 16'h0, 0); chk("Z_c3_r1", r1[3], 16'h0); tick();

    // Random traffic, with a reset landing while slots are in flight
    pa = 3'd0;
    for (int n = 0; n < 300; n++) begin
      if (n == 150) begin
        pa = 3'($urandom_range(1, 7));
        drive(1, pa, pa, pa, 16'($urandom), 1); tick();
        drive(1, pa, pa, pa, 16'h0, 0); tick();
        reset_pulse(); tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          drive(0, 3'd0, pa, pa, 16'hFFFF, 1);
          for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_rst_u%0d_r1_c%0d", i, k), r1[i], 16'h0);
            chk($sformatf("post_rst_u%0d_b1_c%0d", i, k), 16'(b1[i]), 16'h0);
          end
          tick();
        end
      end
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 4) != 0));
      tick();
    end

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
